// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_stall_ctrl_pkg;

  typedef enum logic [0:0] {MEMC_IDLE, MEMC_WAIT} memc_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO        = 5'd0;

  // A load in EX whose destination is read by the instruction in ID; x0 never hazards.
  function automatic logic load_use_hazard(input logic [1:0] result_src_e,
                                           input logic [4:0] rd_e,
                                           input logic [4:0] rs1_d,
                                           input logic [4:0] rs2_d);
    return (result_src_e == RESULT_SRC_LOAD) && (rd_e != REG_ZERO) &&
           ((rs1_d == rd_e) || (rs2_d == rd_e));
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_dmem_wait_fsm.sv
// Request/ready handshake tracker for multi-cycle data-memory accesses,
// with a saturating wait counter and a sticky timeout flag.
module dmem_wait_fsm
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_acc_m,
  input  logic dmem_ready,
  output logic mem_stall,
  output logic dmem_req,
  output logic mem_timeout
);

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYC);

  memc_state_t state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    mem_stall     = 1'b0;
    dmem_req      = 1'b0;
    unique case (state_q)
      MEMC_IDLE: begin
        dmem_req = mem_acc_m;
        if (mem_acc_m && !dmem_ready) begin
          mem_stall  = 1'b1;
          state_d    = MEMC_WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      MEMC_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d    = MEMC_IDLE;
          wait_cnt_d = 16'd0;
        end else begin
          mem_stall = 1'b1;
          // No abort on timeout: the access keeps waiting, only the flag is raised.
          if (wait_cnt_q == TIMEOUT_VAL) mem_timeout_d = 1'b1;
          else                           wait_cnt_d    = wait_cnt_q + 16'd1;
        end
      end
    endcase
    if (rst) begin
      mem_stall = 1'b0;
      dmem_req  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= MEMC_IDLE;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline: memory wait,
// branch flush and load-use bubble resolution plus a stall-cycle counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemAccM,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             StallE,
  output logic             FlushE,
  output logic             StallM,
  output logic             FlushW,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  logic             mem_stall;
  logic             lw_stall;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  dmem_wait_fsm #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_dmem_wait_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_acc_m  (MemAccM),
    .dmem_ready (dmem_ready),
    .mem_stall  (mem_stall),
    .dmem_req   (dmem_req),
    .mem_timeout(mem_timeout)
  );

  assign lw_stall = load_use_hazard({1'b0, LoadE}, RdE, Rs1D, Rs2D);

  // Memory stall freezes everything and defers branch/load-use handling until EX moves.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    StallE = 1'b0;
    FlushE = 1'b0;
    StallM = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      StallF = 1'b0;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (StallF && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule
